// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes an instruction plus operands into the ALU bundle behind a registered skid buffer.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: stall after issuing an illegal instruction until flush.
module alu_issue_stage #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [31:0]     pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ctrl_ALUopcode,
  output logic [XLEN-1:0] data_operandA,
  output logic [XLEN-1:0] data_operandB,
  output logic [31:0]     out_pc,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [31:0]     pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam bundle_t RESET_BUNDLE = '{ctrl: 4'b0000, a: '0, b: '0, pc: RESET_PC_TAG,
                                       rd: 5'd0, reg_write: 1'b0, illegal: 1'b0};

  state_e  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    trap_q, trap_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;

  bundle_t     dec_bundle;
  logic        dec_illegal;
  logic        accept;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;
  logic        unused_rs_idx;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign i_imm         = {{20{instruction[31]}}, instruction[31:20]};
  assign s_imm         = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign u_imm         = {instruction[31:12], 12'h000};
  assign unused_rs_idx = ^instruction[24:15];

  assign accept = in_valid & in_ready_q & ~flush;

  // Instruction decode into a candidate bundle; illegal encodings collapse to a NOP.
  always_comb begin
    dec_bundle           = '0;
    dec_bundle.pc        = pc;
    dec_bundle.rd        = instruction[11:7];
    dec_illegal          = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_bundle.a         = rs1_data;
        dec_bundle.b         = rs2_data;
        dec_bundle.ctrl      = {funct7[5] & ((funct3 == 3'b000) || (funct3 == 3'b101)), funct3};
        dec_bundle.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_illegal = 1'b0;
        end else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec_illegal = 1'b0;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_bundle.a         = rs1_data;
        dec_bundle.b         = i_imm;
        dec_bundle.ctrl      = {funct7[5] & (funct3 == 3'b101), funct3};
        dec_bundle.reg_write = 1'b1;
        case (funct3)
          3'b001:  dec_illegal = (funct7 != 7'b0000000);
          3'b101:  dec_illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
          default: dec_illegal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_bundle.b         = u_imm;
        dec_bundle.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_bundle.a         = pc;
        dec_bundle.b         = u_imm;
        dec_bundle.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec_bundle.a         = rs1_data;
        dec_bundle.b         = i_imm;
        dec_bundle.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec_bundle.a         = rs1_data;
        dec_bundle.b         = s_imm;
        dec_bundle.reg_write = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_bundle.ctrl      = 4'b0000;
      dec_bundle.a         = '0;
      dec_bundle.b         = '0;
      dec_bundle.rd        = 5'd0;
      dec_bundle.reg_write = 1'b0;
      dec_bundle.illegal   = 1'b1;
    end else begin
      dec_bundle.reg_write = dec_bundle.reg_write & (dec_bundle.rd != 5'd0);
    end
  end

  // Buffer next-state: flush wins; out_pc parks at the tag whenever the output goes invalid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    trap_d  = trap_q;
    if (flush) begin
      state_d   = ST_EMPTY;
      main_d.pc = RESET_PC_TAG;
      trap_d    = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_bundle;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept && !out_ready) begin
            skid_d  = dec_bundle;
            state_d = ST_SKID;
          end else if (accept && out_ready) begin
            main_d  = dec_bundle;
            state_d = ST_FULL;
          end else if (out_ready) begin
            main_d.pc = RESET_PC_TAG;
            state_d   = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          main_d.pc = RESET_PC_TAG;
          state_d   = ST_EMPTY;
        end
      endcase
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      trap_d = trap_q | (accept & dec_bundle.illegal);
`else
      trap_d = 1'b0;
`endif
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID) & ~trap_d;
  end

  // State and bundle registers; handshake outputs are precomputed so they come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_BUNDLE;
      skid_q      <= RESET_BUNDLE;
      trap_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      trap_q      <= trap_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign ctrl_ALUopcode = main_q.ctrl;
  assign data_operandA  = main_q.a;
  assign data_operandB  = main_q.b;
  assign out_pc         = main_q.pc;
  assign rd             = main_q.rd;
  assign reg_write      = main_q.reg_write;
  assign illegal        = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected bundles are queued on acceptance and compared on issue.
module tb_alu_issue_stage;

  localparam logic [31:0] TAG = 32'hBAD0_0000;

  logic        clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic        reg_write, illegal;
  logic [31:0] instruction, pc, rs1_data, rs2_data, data_operandA, data_operandB, out_pc;
  logic [3:0]  ctrl_ALUopcode;
  logic [4:0]  rd;

  int n_checks   = 0;
  int n_errors   = 0;
  int accept_cnt = 0;
  int issue_cnt  = 0;

  logic [106:0] exp_cur    = '0;
  logic [106:0] prev_out   = '0;
  logic         prev_stall = 1'b0;
  logic [106:0] sb[$];
  logic [106:0] obs;

  assign obs = {ctrl_ALUopcode, data_operandA, data_operandB, out_pc, rd, reg_write, illegal};

  alu_issue_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_ALUopcode(ctrl_ALUopcode), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .out_pc(out_pc), .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [106:0] mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] p, input logic [4:0] r, input logic w,
                                      input logic il);
    return {c, a, b, p, r, w, il};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [106:0] e);
    in_valid    = 1'b1;
    instruction = ins;
    pc          = p;
    rs1_data    = a1;
    rs2_data    = a2;
    exp_cur     = e;
  endtask

  // Scoreboard monitor at the falling edge, where handshakes are stable.
  always @(negedge clock) begin
    if (reset || flush) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", obs, prev_out);
      if (out_valid && out_ready) begin
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) check("issue", obs, sb.pop_front());
        issue_cnt++;
      end else if (!out_valid) begin
        check("idle_pc", out_pc, TAG);
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_cur);
        accept_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = obs;
    end
  end

  initial begin
    int          acc0, iss0;
    logic [31:0] d1, d2;
    logic [2:0]  f3s [3];
    logic [3:0]  cs  [3];
    logic [6:0]  f7;
    f3s = '{3'b100, 3'b110, 3'b111};
    cs  = '{4'b0100, 4'b0110, 4'b0111};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_bundle", obs, mk(4'h0, 32'h0, 32'h0, TAG, 5'd0, 1'b0, 1'b0));
    reset = 1'b0;

    // Decode coverage, streaming with out_ready high.
    out_ready = 1'b1;
    drive(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(4'b0000, 32'd5, 32'd7, 32'h100, 5'd3, 1'b1, 1'b0));
    tick(); check("lat1_valid", out_valid, 1'b1);
    drive(32'h402081B3, 32'h104, 32'd5, 32'd7, mk(4'b1000, 32'd5, 32'd7, 32'h104, 5'd3, 1'b1, 1'b0));
    tick(); check("sub_ctrl", ctrl_ALUopcode, 4'b1000);
    drive(32'h40335293, 32'h108, 32'h8000_0000, 32'h1,
          mk(4'b1101, 32'h8000_0000, 32'h403, 32'h108, 5'd5, 1'b1, 1'b0));
    tick(); check("srai_b", data_operandB[4:0], 5'd3);
    drive(32'hFFF00093, 32'h10C, 32'h55, 32'h66, mk(4'b0000, 32'h55, 32'hFFFF_FFFF, 32'h10C, 5'd1, 1'b1, 1'b0));
    tick();
    drive(32'h123453B7, 32'h110, 32'h99, 32'h98, mk(4'b0000, 32'h0, 32'h1234_5000, 32'h110, 5'd7, 1'b1, 1'b0));
    tick(); check("lui_b", data_operandB, 32'h1234_5000);
    drive(32'h00001517, 32'h114, 32'h11, 32'h12, mk(4'b0000, 32'h114, 32'h1000, 32'h114, 5'd10, 1'b1, 1'b0));
    tick();
    drive(32'h0020A423, 32'h118, 32'h2000, 32'h77, mk(4'b0000, 32'h2000, 32'h8, 32'h118, 5'd8, 1'b0, 1'b0));
    tick();
    drive(32'hFFC12203, 32'h11C, 32'h3000, 32'h5, mk(4'b0000, 32'h3000, 32'hFFFF_FFFC, 32'h11C, 5'd4, 1'b1, 1'b0));
    tick();
    drive(32'h00208033, 32'h120, 32'h21, 32'h22, mk(4'b0000, 32'h21, 32'h22, 32'h120, 5'd0, 1'b0, 1'b0));
    tick(); check("x0_no_write", reg_write, 1'b0);
    drive(32'h0030D093, 32'h124, 32'hF000_0000, 32'h0, mk(4'b0101, 32'hF000_0000, 32'h3, 32'h124, 5'd1, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: three offered, two held, in order on release.
    acc0 = accept_cnt; iss0 = issue_cnt;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d1 = $urandom; d2 = $urandom;
      drive(rtype(7'b0, 5'(k + 2), 5'(k + 1), f3s[k], 5'(k + 10)), 32'h300 + 32'(4 * k), d1, d2,
            mk(cs[k], d1, d2, 32'h300 + 32'(4 * k), 5'(k + 10), 1'b1, 1'b0));
      if (k < 2) tick();
      if (k == 1) check("bp_in_ready", in_ready, 1'b0);
    end
    repeat (3) begin
      tick();
      check("bp_stall_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
    end
    check("bp_accepts", accept_cnt - acc0, 2);
    out_ready = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_accept3", accept_cnt - acc0, 3);
    check("bp_issued", issue_cnt - iss0, 3);

    // Throughput: one issue per cycle.
    iss0 = issue_cnt;
    for (int k = 0; k < 8; k++) begin
      d1 = $urandom; d2 = $urandom;
      f7 = k[0] ? 7'b0100000 : 7'b0000000;
      check("tp_in_ready", in_ready, 1'b1);
      drive(rtype(f7, 5'(k + 9), 5'(k), 3'b000, 5'(k + 1)), 32'h400 + 32'(4 * k), d1, d2,
            mk(k[0] ? 4'b1000 : 4'b0000, d1, d2, 32'h400 + 32'(4 * k), 5'(k + 1), 1'b1, 1'b0));
      tick();
      check("tp_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("tp_issued", issue_cnt - iss0, 8);

    // Flush while in SKID with a new instruction offered.
    out_ready = 1'b0;
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b000, 5'd6), 32'h500, 32'h1, 32'h2, mk(4'h0, 32'h1, 32'h2, 32'h500, 5'd6, 1'b1, 1'b0));
    tick();
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b000, 5'd7), 32'h504, 32'h3, 32'h4, mk(4'h0, 32'h3, 32'h4, 32'h504, 5'd7, 1'b1, 1'b0));
    tick();
    check("pre_flush_skid", in_ready, 1'b0);
    acc0 = accept_cnt;
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b000, 5'd8), 32'h508, 32'h5, 32'h6, mk(4'h0, 32'h5, 32'h6, 32'h508, 5'd8, 1'b1, 1'b0));
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_pc", out_pc, TAG);
    check("flush_accepts", accept_cnt - acc0, 0);

    // Flush in FULL with in_ready high: the offered instruction must be dropped.
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b110, 5'd9), 32'h600, 32'h7, 32'h8, mk(4'h6, 32'h7, 32'h8, 32'h600, 5'd9, 1'b1, 1'b0));
    tick();
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b111, 5'd9), 32'h604, 32'h9, 32'hA, mk(4'h7, 32'h9, 32'hA, 32'h604, 5'd9, 1'b1, 1'b0));
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_no_accept", out_valid, 1'b0);

    // Reset mid-stream.
    out_ready = 1'b0;
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b100, 5'd11), 32'h700, 32'hAA, 32'hBB, mk(4'h4, 32'hAA, 32'hBB, 32'h700, 5'd11, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_bundle", obs, mk(4'h0, 32'h0, 32'h0, TAG, 5'd0, 1'b0, 1'b0));

    // Illegal instruction handling.
    out_ready = 1'b1;
    acc0 = accept_cnt;
    drive(32'hFFFF_FFFF, 32'h800, 32'h1, 32'h2, mk(4'h0, 32'h0, 32'h0, 32'h800, 5'd0, 1'b0, 1'b1));
    tick();
    check("ill_flag", illegal, 1'b1);
    check("ill_rw", reg_write, 1'b0);
    drive(rtype(7'b0, 5'd2, 5'd1, 3'b000, 5'd12), 32'h804, 32'hC, 32'hD, mk(4'h0, 32'hC, 32'hD, 32'h804, 5'd12, 1'b1, 1'b0));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    repeat (3) begin
      check("trap_in_ready", in_ready, 1'b0);
      tick();
    end
    check("trap_accepts", accept_cnt - acc0, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("trap_release", in_ready, 1'b1);
    tick();
`else
    check("ill_in_ready", in_ready, 1'b1);
    tick();
    check("ill_next_valid", out_valid, 1'b1);
    check("ill_next_rd", rd, 5'd12);
`endif
    in_valid = 1'b0;
    repeat (2) tick();
    check("ill_accepts", accept_cnt - acc0, 2);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Drives the ALU from the decode side: takes a fetched RV32I instruction plus register-file read data and produces the ALU-facing bundle.
- Bundle contents: ctrl_ALUopcode, data_operandA, data_operandB, rd, reg_write and illegal.
- Registered ID/EX boundary with valid/ready handshakes on both sides and a 2-entry skid buffer, so in_ready is a pure register output.
- Supports a pipeline flush from branch/trap logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0, value driven on out_pc while the output is invalid.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept; registered
- instruction  in  32  RV32I instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register file read port 1
- rs2_data  in  32  register file read port 2
- flush  in  1  discard all held entries
- out_valid  out  1  bundle valid toward EX
- out_ready  in  1  EX accepts the bundle
- ctrl_ALUopcode  out  4  ALU function: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, SRL 0101, SRA 1101, XOR 0100, OR 0110, AND 0111
- data_operandA  out  32  ALU operand A
- data_operandB  out  32  ALU operand B
- out_pc  out  32  pc of the issued instruction
- rd  out  5  destination register
- reg_write  out  1  writeback enable; forced 0 when rd==0
- illegal  out  1  instruction not supported by the decoder

Behaviour:
- Reset values: out_valid=0, in_ready=1, ctrl_ALUopcode=0000, data_operandA=0, data_operandB=0, rd=0, reg_write=0, illegal=0, out_pc=RESET_PC_TAG. Both buffer entries are invalid.
- Decode is combinational on the inputs and captured on an accepted transfer (in_valid & in_ready). Latency is 1 cycle from acceptance to out_valid.
- Decode rules:
  - OP (0110011): A=rs1_data, B=rs2_data. ctrl = {funct7[5] & (funct3==000 | funct3==101), funct3}.
  - OP with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not 000/101: illegal.
  - OP-IMM (0010011): A=rs1_data, B=sign-extended imm[11:0]. ctrl = {funct7[5] & (funct3==101), funct3}.
  - OP-IMM shifts (funct3 001/101) with imm[11:5] not 0000000/0100000, or SLLI with 0100000: illegal.
  - LUI: A=0, B={imm[31:12],12'b0}, ADD.
  - AUIPC: A=pc, B=U-imm, ADD.
  - LOAD (0000011): A=rs1_data, B=I-imm, ADD.
  - STORE (0100011): A=rs1_data, B=S-imm, ADD, reg_write=0.
  - Any other opcode: illegal=1, reg_write=0, ctrl=ADD, A=B=0.
- Buffer FSM:
  - EMPTY: out_valid=0, in_ready=1. Accept -> FULL.
  - FULL: main entry valid, in_ready=1. Transitions:
    - accept & ~out_ready -> SKID; the new entry goes to the skid slot.
    - accept & out_ready -> FULL; the main entry is replaced.
    - ~accept & out_ready -> EMPTY.
  - SKID: both entries valid, in_ready=0. On out_ready, skid moves to main -> FULL.
- Output stability: outputs change only on an out_valid & out_ready transfer or on entry into FULL from EMPTY. While out_valid=1 & out_ready=0, all outputs hold stable.
- Flush:
  - Next state is EMPTY with all valids cleared; any same-cycle input is not accepted.
  - Flush has priority over every other event, including out_ready.
- Reset mid-operation behaves like flush and also restores all output reset values.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: illegal instructions are issued with illegal=1. The stage then drops in_ready and accepts nothing until flush is asserted, so the trap logic must flush.
- Undefined: illegal instructions are issued as a NOP (ADD, A=B=0, reg_write=0) with illegal=1, and the stream continues without stalling.

Test Plan:
- Decode R-type: 0x002081B3 with rs1=5, rs2=7 -> ctrl=0000, A=5, B=7, rd=3, reg_write=1. Then 0x402081B3 -> ctrl=1000.
- Decode immediates: 0x40335293 -> ctrl=1101, B[4:0]=3, rd=5. 0xFFF00093 -> ctrl=0000, B=0xFFFFFFFF. LUI 0x123453B7 -> A=0, B=0x12345000, rd=7.
- Backpressure: out_ready=0 while 3 instructions are offered -> exactly 2 accepted, in_ready=0 the cycle after the second, outputs held. Releasing out_ready -> all 3 issued in order with no loss or duplication.
- Throughput: in_valid=1 and out_ready=1 continuously for 8 instructions -> one issue per cycle after 1-cycle latency, in_ready never drops.
- Flush in SKID with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction is not accepted. Reset asserted mid-stream -> all outputs at reset values next cycle.
- Illegal: 0xFFFFFFFF -> illegal=1, reg_write=0. With the macro, in_ready stays 0 until flush. Without it, the next instruction issues the following cycle.
